fetch_unit: RTL

- Instruction fetch stage directly downstream of the program counter.
- Consumes the counter value, issues synchronous instruction-memory reads, and buffers returned words with their addresses in a small FIFO for decode.
- Controls the counter only through its load path: holds it when stalled, redirects it on a taken branch from execute.
- Counter decrement is never used.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FetchAddrW     = 8;
  localparam int unsigned FetchInstrW    = 16;
  localparam int unsigned FetchFifoDepth = 2;

  // Count must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned FetchCntW = cnt_width(FetchFifoDepth);

  typedef struct packed {
    logic [FetchInstrW-1:0] instr;
    logic [FetchAddrW-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: counter load path, instruction memory and decode handshake.
interface fetch_if #(
  parameter int unsigned ADDR_W  = fetch_pkg::FetchAddrW,
  parameter int unsigned INSTR_W = fetch_pkg::FetchInstrW
);
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_sel;
  logic [ADDR_W-1:0]  pc_next;
  logic               pc_dec;
  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  // Fetch unit side.
  modport master (
    input  pc_in, imem_rdata, redirect_valid, redirect_target, instr_ready,
    output pc_sel, pc_next, pc_dec, imem_rd_en, imem_addr, instr_valid, instr, instr_pc
  );

  // Counter / memory / execute / decode side.
  modport slave (
    output pc_in, imem_rdata, redirect_valid, redirect_target, instr_ready,
    input  pc_sel, pc_next, pc_dec, imem_rd_en, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries; flush beats push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = FetchFifoDepth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [cnt_width(Depth)-1:0] count_o,
  output fetch_entry_t               head_o
);
  localparam int unsigned CntW = cnt_width(Depth);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Next-state for pointers and count; flush empties everything.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q < CntW'(Depth)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers; storage clears so the head reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC counter load path, issues imem reads
// and buffers returned words for decode. Define FETCH_BYPASS_EN to let a
// returning word reach decode in its return cycle when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = FetchAddrW,
  parameter int unsigned INSTR_W    = FetchInstrW,
  parameter int unsigned FIFO_DEPTH = FetchFifoDepth
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);
  localparam int unsigned CntW = cnt_width(FIFO_DEPTH);
  localparam int unsigned OccW = CntW + 1;

  logic [CntW-1:0]   fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_data;
  logic              fifo_valid;
  logic              fifo_push;
  logic              fifo_pop;
  logic              pop_hs;
  logic              bypass;
  logic              issue;
  logic [OccW-1:0]   occ_rem;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_q, tag_d;

  fetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .flush_i     (bus.redirect_valid),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // Issue decision, counter control, decode outputs and buffer push/pop.
  always_comb begin
    fifo_valid = (fifo_count != '0);
`ifdef FETCH_BYPASS_EN
    bypass = !fifo_valid && inflight_q && !bus.redirect_valid;
`else
    bypass = 1'b0;
`endif
    if (bypass) begin
      bus.instr_valid = 1'b1;
      bus.instr       = bus.imem_rdata;
      bus.instr_pc    = tag_q;
    end else begin
      bus.instr_valid = fifo_valid;
      bus.instr       = fifo_head.instr;
      bus.instr_pc    = fifo_head.pc;
    end

    pop_hs   = bus.instr_valid && bus.instr_ready;
    fifo_pop = fifo_valid && bus.instr_ready;

    // A pop this cycle frees a slot for the issue decision.
    occ_rem = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop_hs);
    issue   = !bus.redirect_valid && (occ_rem < OccW'(FIFO_DEPTH));

    // A word handed straight to decode is not also buffered.
    fifo_push       = inflight_q && !bus.redirect_valid && !(bypass && bus.instr_ready);
    push_data.instr = bus.imem_rdata;
    push_data.pc    = tag_q;

    bus.imem_rd_en = issue;
    bus.imem_addr  = bus.pc_in;
    bus.pc_sel     = !issue;
    bus.pc_next    = bus.redirect_valid ? bus.redirect_target : bus.pc_in;
    bus.pc_dec     = 1'b0;

    inflight_d = issue;
    tag_d      = issue ? bus.pc_in : tag_q;
  end

  // In-flight flag and address tag of the outstanding read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

endmodule
